mem_load_debug_ctrl: RTL
========================

// Module: mem_load_debug_ctrl
// PURPOSE
//  Host-side load/run/debug controller in front of the riscv core.
//  - Takes a valid/ready command stream and drives the core's external-memory load ports, core reset, halt and DebugSel.
//  - Returns DebugOutput samples on a response channel.
//  - Generalises the hand-driven load/halt sequence: parametrised beat width, address width and register select.
//  - Adds single/multi-cycle stepping and error reporting.
// PARAMETERS
//  ADDR_W     9   memory word address width (InstExMemAddress/DataExMemAddress)
//  DATA_W     32  data word width
//  LANES      2   words written per load beat (Data1/Data2 pairs)
//  SEL_W      5   debug register select width
//  CNT_W      16  step count width
//  RST_CYC    2   cycles core_reset is held on RUN; legal range 1..255
//  READ_LAT   1   cycles from dbg_sel change to dbg_data valid; legal range 0..7
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  reset_n      in   1              asynchronous, active-low reset
//  cmd_valid    in   1              command valid
//  cmd_ready    out  1              command accepted when valid&&ready
//  cmd_op       in   3              opcode (mld_pkg::mld_op_e)
//  cmd_addr     in   ADDR_W         load address / debug select (low SEL_W bits)
//  cmd_data     in   LANES*DATA_W   load beat, lane0 in LSBs
//  cmd_count    in   CNT_W          STEP cycle count
//  rsp_valid    out  1              response valid, held until rsp_ready
//  rsp_ready    in   1              response accepted
//  rsp_data     out  DATA_W         captured dbg_data
//  err          out  1              sticky illegal-command flag
//  core_reset   out  1              active-high reset to core
//  core_load_en out  1              enable_load_ex_mem
//  core_halt    out  1              enable_halt
//  imem_we      out  1              instruction-memory write strobe
//  dmem_we      out  1              data-memory write strobe
//  mem_addr     out  ADDR_W         shared write address
//  mem_wdata    out  LANES*DATA_W   shared write data
//  dbg_sel      out  SEL_W          DebugSel
//  dbg_data     in   DATA_W         DebugOutput
// BEHAVIOUR
//  Reset values (asynchronous, reset_n=0):
//  - state=S_LOAD, core_reset=1, core_load_en=1, core_halt=1.
//  - cmd_ready=1; rsp_valid=0, rsp_data=0, err=0.
//  - imem_we=0, dmem_we=0, mem_addr=0, mem_wdata=0, dbg_sel=0.
//  Opcodes: 0 NOP, 1 LOAD_I, 2 LOAD_D, 3 RUN, 4 HALT, 5 STEP, 6 READ, 7 RD_CNT.
//  All outputs are registered. A command accepted at edge N takes effect at edge N+1.
//  S_LOAD:
//  - LOAD_I/LOAD_D write one beat: mem_addr/mem_wdata latched, and imem_we or dmem_we high for exactly 1 cycle.
//  - Back-to-back beats are allowed, 1 per cycle.
//  - RUN -> S_RST.
//  S_RST: core_load_en=0, core_reset=1 for RST_CYC cycles, cmd_ready=0; then -> S_RUN.
//  S_RUN: core_reset=0, core_halt=0.
//  - HALT -> S_HALT, with core_halt=1 from edge N+1.
//  - LOAD_I/LOAD_D -> S_LOAD: core_reset=1, core_load_en=1, and the beat is written.
//  S_HALT: core_halt=1. Legal commands:
//  - STEP: -> S_STEP, core_halt=0 for max(cmd_count,1) cycles, cmd_ready=0; then -> S_HALT.
//  - READ: dbg_sel<=cmd_addr[SEL_W-1:0]; wait READ_LAT cycles; capture dbg_data into rsp_data; rsp_valid=1; cmd_ready=0 until rsp_ready.
//  - RUN: -> S_RUN without core reset.
//  - LOAD_*: -> S_LOAD.
//  Illegal (op,state) pairs:
//  - The command is accepted and dropped, and err sets.
//  - err clears only on reset.
//  - Illegal pairs: HALT outside S_RUN; STEP/READ outside S_HALT; any op while busy never reaches this, because cmd_ready=0 while busy.
//  - NOP is always legal.
//  Reset mid-STEP/READ: abort, return to reset values, and discard any pending response.
//  mem_addr takes cmd_addr directly and has no auto-increment; address 2**ADDR_W-1 is a legal write.
// CONFIGURATION
//  MLD_CYCLE_CNT_EN defined:
//  - 32-bit counter increments every cycle with core_reset==0 && core_halt==0, and wraps at 2**32-1 -> 0.
//  - The counter clears on entry to S_LOAD.
//  - RD_CNT is legal in S_HALT and returns the counter as a READ, zero-extended or truncated to DATA_W.
//  MLD_CYCLE_CNT_EN undefined: no counter, and RD_CNT is illegal (sets err).
// STRUCTURE
//  mld_pkg: mld_op_e (3-bit opcode enum), mld_state_e (S_LOAD,S_RST,S_RUN,S_HALT,S_STEP,S_READ,S_RSP), default widths.
//  Sub-module mld_down_timer: loadable CNT_W down-counter with done pulse, shared by S_RST, S_STEP and the READ_LAT wait.
// TESTING
//  1. Reset, then LOAD_I addr=0, data={32'h0003_8303,32'h0010_0393} -> imem_we 1 cycle, mem_addr=0; core_reset=1, core_load_en=1 throughout.
//  2. LOAD_D addr=9'h1FF data={32'hFF,32'h8F00}, then RUN -> dmem_we 1 cycle at 0x1FF; core_reset high exactly RST_CYC=2 cycles; then core_halt=0, core_reset=0.
//  3. In S_RUN, HALT; STEP count=3 -> core_halt low exactly 3 cycles; cmd_ready low those 3 cycles; back to S_HALT. STEP count=0 -> 1 cycle low.
//  4. In S_HALT, READ addr=5'b11010 with dbg_data=32'hDEAD_BEEF; hold rsp_ready=0 for 4 cycles -> dbg_sel=26; rsp_valid held with rsp_data=DEADBEEF; cmd_ready=0 until handshake.
//  5. STEP in S_RUN, and HALT in S_LOAD -> both accepted; err=1 and stays 1; no change to core_halt or core_reset.
//  6. reset_n low during S_STEP -> all outputs return to reset values asynchronously. With MLD_CYCLE_CNT_EN, RD_CNT after RUN + 10 cycles + HALT -> 10.

Source files
------------

// File: rtl/mem_load_debug_ctrl_pkg.sv
// mld_pkg: opcodes, FSM states and default widths for mem_load_debug_ctrl.
// RD_CNT legality depends on MLD_CYCLE_CNT_EN.
package mld_pkg;
    typedef enum logic [2:0] {
        OP_NOP, OP_LOAD_I, OP_LOAD_D, OP_RUN, OP_HALT, OP_STEP, OP_READ, OP_RD_CNT
    } mld_op_e;

    typedef enum logic [2:0] {
        S_LOAD, S_RST, S_RUN, S_HALT, S_STEP, S_READ, S_RSP
    } mld_state_e;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int LANES_DEF  = 2;
    localparam int SEL_W_DEF  = 5;
    localparam int CNT_W_DEF  = 16;

    // Busy states never see a command, so only the idle states matter here.
    function automatic logic op_legal(input mld_op_e op, input mld_state_e st);
        case (op)
            OP_HALT:           return st == S_RUN;
            OP_STEP, OP_READ:  return st == S_HALT;
`ifdef MLD_CYCLE_CNT_EN
            OP_RD_CNT:         return st == S_HALT;
`else
            OP_RD_CNT:         return 1'b0;
`endif
            default:           return 1'b1;
        endcase
    endfunction
endpackage

// File: rtl/mem_load_debug_ctrl_if.sv
// mem_load_debug_ctrl_if: host command and response channels.
interface mem_load_debug_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int CNT_W  = 16
);
    import mld_pkg::*;
    logic                    cmd_valid;
    logic                    cmd_ready;
    mld_op_e                 cmd_op;
    logic [ADDR_W-1:0]       cmd_addr;
    logic [LANES*DATA_W-1:0] cmd_data;
    logic [CNT_W-1:0]        cmd_count;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_W-1:0]       rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_count, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_count, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mem_load_debug_ctrl_timer.sv
// mld_down_timer: loadable down-counter; done_o marks the last cycle of a loaded interval.
module mld_down_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    assign done_o = cnt_q == CNT_W'(1);
endmodule

// File: rtl/mem_load_debug_ctrl.sv
// mem_load_debug_ctrl: host load/run/step/debug-read controller for the riscv core.
// Define MLD_CYCLE_CNT_EN to add the run-cycle counter readable with RD_CNT.
module mem_load_debug_ctrl
    import mld_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LANES    = LANES_DEF,
    parameter int SEL_W    = SEL_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int RST_CYC  = 2,
    parameter int READ_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mem_load_debug_ctrl_if.slave    bus,
    output logic                    err,
    output logic                    core_reset,
    output logic                    core_load_en,
    output logic                    core_halt,
    output logic                    imem_we,
    output logic                    dmem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANES*DATA_W-1:0] mem_wdata,
    output logic [SEL_W-1:0]        dbg_sel,
    input  logic [DATA_W-1:0]       dbg_data
);
    mld_state_e       state_q;
    logic             acc, legal, ld, done;
    logic [CNT_W-1:0] ld_val;
    logic [DATA_W-1:0] cap;

    assign acc   = bus.cmd_valid && bus.cmd_ready;
    assign legal = op_legal(bus.cmd_op, state_q);
    // One timer serves the reset hold, the step window and the read latency.
    assign ld    = acc && legal && (bus.cmd_op == OP_RUN ? state_q == S_LOAD
                                    : bus.cmd_op inside {OP_STEP, OP_READ, OP_RD_CNT});
    assign ld_val = bus.cmd_op == OP_RUN  ? CNT_W'(RST_CYC)
                  : bus.cmd_op == OP_STEP ? (bus.cmd_count == '0 ? CNT_W'(1) : bus.cmd_count)
                  : CNT_W'(READ_LAT + 1);

    mld_down_timer #(.CNT_W(CNT_W)) u_tmr (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (ld),
        .val_i  (ld_val),
        .done_o (done)
    );

`ifdef MLD_CYCLE_CNT_EN
    logic [31:0] cyc_q;
    logic        rd_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q    <= '0;
            rd_cnt_q <= 1'b0;
        end else begin
            cyc_q <= state_q == S_LOAD ? '0 : (!core_reset && !core_halt) ? cyc_q + 32'd1 : cyc_q;
            if (ld) rd_cnt_q <= bus.cmd_op == OP_RD_CNT;
        end
    end

    assign cap = rd_cnt_q ? DATA_W'(cyc_q) : dbg_data;
`else
    assign cap = dbg_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_LOAD;
            core_reset    <= 1'b1;
            core_load_en  <= 1'b1;
            core_halt     <= 1'b1;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            err           <= 1'b0;
            imem_we       <= 1'b0;
            dmem_we       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            dbg_sel       <= '0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            if (acc && !legal) err <= 1'b1;
            case (state_q)
                S_LOAD, S_RUN, S_HALT: if (acc && legal) begin
                    case (bus.cmd_op)
                        OP_LOAD_I, OP_LOAD_D: begin
                            state_q      <= S_LOAD;
                            core_reset   <= 1'b1;
                            core_load_en <= 1'b1;
                            core_halt    <= 1'b1;
                            imem_we      <= bus.cmd_op == OP_LOAD_I;
                            dmem_we      <= bus.cmd_op == OP_LOAD_D;
                            mem_addr     <= bus.cmd_addr;
                            mem_wdata    <= bus.cmd_data;
                        end
                        OP_RUN: begin
                            if (state_q == S_LOAD) begin
                                state_q       <= S_RST;
                                core_load_en  <= 1'b0;
                                bus.cmd_ready <= 1'b0;
                            end else begin
                                state_q   <= S_RUN;
                                core_halt <= 1'b0;
                            end
                        end
                        OP_HALT: begin
                            state_q   <= S_HALT;
                            core_halt <= 1'b1;
                        end
                        OP_STEP: begin
                            state_q       <= S_STEP;
                            core_halt     <= 1'b0;
                            bus.cmd_ready <= 1'b0;
                        end
                        OP_READ, OP_RD_CNT: begin
                            state_q       <= S_READ;
                            dbg_sel       <= bus.cmd_addr[SEL_W-1:0];
                            bus.cmd_ready <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_RST: if (done) begin
                    state_q       <= S_RUN;
                    core_reset    <= 1'b0;
                    core_halt     <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
                S_STEP: if (done) begin
                    state_q       <= S_HALT;
                    core_halt     <= 1'b1;
                    bus.cmd_ready <= 1'b1;
                end
                S_READ: if (done) begin
                    state_q       <= S_RSP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data  <= cap;
                end
                S_RSP: if (bus.rsp_ready) begin
                    state_q       <= S_HALT;
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end
endmodule
